frame_length_monitor: RTL and testbench

// - Sits directly downstream of the framer; consumes its valid/sop/eop stream.
// - Measures each frame's length in valid beats and flags runt/giant frames.
// - Flags protocol anomalies and keeps saturating frame and error counters.
// - Reports one registered status pulse per completed frame.
//

---
 rtl/frame_length_monitor.sv | 153 +++++++++++++++
 tb/tb_frame_length_monitor.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_length_monitor.sv
// Frame length monitor: measures framer frames in valid beats, flags runt/giant
// frames and protocol anomalies, and keeps saturating frame and error counters.
module frame_length_monitor #(
  parameter int unsigned MIN_LEN = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_valid,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_clear,
  output logic             o_done,
  output logic [LEN_W-1:0] o_frameLen,
  output logic             o_runt,
  output logic             o_giant,
  output logic             o_protoErr,
  output logic [CNT_W-1:0] o_frameCount,
  output logic [CNT_W-1:0] o_errCount
);

  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [0:0] {IDLE, IN_FRAME} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             done_q, done_d;
  logic             runt_q, runt_d;
  logic             giant_q, giant_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             complete;
  logic [LEN_W-1:0] comp_len;
  logic [LEN_W-1:0] beat_inc;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;

  // Next-state, completion status and counter update
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    runt_d      = 1'b0;
    giant_d     = 1'b0;
    proto_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    complete    = 1'b0;
    comp_len    = '0;
    err_inc     = 2'd0;
    err_sum     = '0;
    beat_inc    = (beat_cnt_q == LEN_SAT) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);

    if (i_valid) begin
      case (state_q)
        IDLE: begin
          if (i_sop && i_eop) begin
            complete = 1'b1;
            comp_len = LEN_W'(1);
          end else if (i_sop) begin
            state_d    = IN_FRAME;
            beat_cnt_d = LEN_W'(1);
          end else begin
            proto_err_d = 1'b1;
          end
        end
        IN_FRAME: begin
          if (i_sop) begin
            // Abandon the open frame; this sop starts a fresh one
            proto_err_d = 1'b1;
            if (i_eop) begin
              complete = 1'b1;
              comp_len = LEN_W'(1);
              state_d  = IDLE;
            end else begin
              beat_cnt_d = LEN_W'(1);
            end
          end else if (i_eop) begin
            complete = 1'b1;
            comp_len = beat_inc;
            state_d  = IDLE;
          end else begin
            beat_cnt_d = beat_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      done_d      = 1'b1;
      frame_len_d = comp_len;
      runt_d      = (comp_len < MIN_L);
      giant_d     = (comp_len > MAX_L) || (comp_len == LEN_SAT);
    end

    err_inc = {1'b0, runt_d | giant_d} + {1'b0, proto_err_d};
    err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_inc);

    if (i_clear) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (complete && (frame_cnt_q != CNT_SAT)) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
      err_cnt_d = err_sum[CNT_W] ? CNT_SAT : err_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
      runt_q      <= 1'b0;
      giant_q     <= 1'b0;
      proto_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      runt_q      <= runt_d;
      giant_q     <= giant_d;
      proto_err_q <= proto_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_done       = done_q;
  assign o_frameLen   = frame_len_q;
  assign o_runt       = runt_q;
  assign o_giant      = giant_q;
  assign o_protoErr   = proto_err_q;
  assign o_frameCount = frame_cnt_q;
  assign o_errCount   = err_cnt_q;

endmodule

// File: tb/tb_frame_length_monitor.sv
// Bench for frame_length_monitor: a default instance and a narrow one (LEN_W=4,
// CNT_W=4, MAX_LEN=8) share stimulus; a per-beat scoreboard checks both.
module tb_frame_length_monitor;

  logic i_clk = 1'b0;
  logic i_arst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_sop = 1'b0;
  logic i_eop = 1'b0;
  logic i_clear = 1'b0;

  logic        o_done, o_runt, o_giant, o_protoErr;
  logic [15:0] o_frameLen;
  logic [31:0] o_frameCount, o_errCount;
  logic        s_done, s_runt, s_giant, s_proto_err;
  logic [3:0]  s_frame_len, s_frame_count, s_err_count;

  frame_length_monitor #(.MIN_LEN(4), .MAX_LEN(64), .LEN_W(16), .CNT_W(32)) u_dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .i_sop(i_sop),
    .i_eop(i_eop), .i_clear(i_clear), .o_done(o_done), .o_frameLen(o_frameLen),
    .o_runt(o_runt), .o_giant(o_giant), .o_protoErr(o_protoErr),
    .o_frameCount(o_frameCount), .o_errCount(o_errCount)
  );

  frame_length_monitor #(.MIN_LEN(4), .MAX_LEN(8), .LEN_W(4), .CNT_W(4)) u_small (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .i_sop(i_sop),
    .i_eop(i_eop), .i_clear(i_clear), .o_done(s_done), .o_frameLen(s_frame_len),
    .o_runt(s_runt), .o_giant(s_giant), .o_protoErr(s_proto_err),
    .o_frameCount(s_frame_count), .o_errCount(s_err_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int              due;
    bit              done;
    bit              proto;
    longint unsigned len_b;
    bit              runt_b;
    bit              giant_b;
    longint unsigned len_s;
    bit              runt_s;
    bit              giant_s;
    longint unsigned fc;
    longint unsigned ec;
    longint unsigned fc4;
    longint unsigned ec4;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model state (true, unbounded beat count)
  bit              m_in = 1'b0;
  longint unsigned m_cnt = 0;
  longint unsigned m_len = 0;
  longint unsigned m_fc = 0, m_ec = 0, m_fc4 = 0, m_ec4 = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Drive one cycle of stimulus, predict its outcome, push the expectation
  task automatic drive(input bit rst_n, input bit v, input bit s, input bit e, input bit clr);
    exp_t            x;
    bit              complete = 1'b0;
    bit              proto = 1'b0;
    bit              runt = 1'b0, gb = 1'b0, gs = 1'b0;
    longint unsigned len = 0;
    i_arst_n = rst_n; i_valid = v; i_sop = s; i_eop = e; i_clear = clr;
    if (!rst_n) begin
      m_in = 1'b0; m_cnt = 0; m_len = 0;
      m_fc = 0; m_ec = 0; m_fc4 = 0; m_ec4 = 0;
    end else begin
      if (v) begin
        if (!m_in) begin
          if (s && e) begin complete = 1'b1; len = 1; end
          else if (s) begin m_in = 1'b1; m_cnt = 1; end
          else proto = 1'b1;
        end else if (s) begin
          proto = 1'b1;
          if (e) begin complete = 1'b1; len = 1; m_in = 1'b0; end
          else m_cnt = 1;
        end else if (e) begin
          complete = 1'b1; len = m_cnt + 1; m_in = 1'b0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (complete) begin
        m_len = len; runt = (len < 4); gb = (len > 64); gs = (len > 8);
      end
      if (clr) begin
        m_fc = 0; m_ec = 0; m_fc4 = 0; m_ec4 = 0;
      end else begin
        m_fc  = sat(m_fc + longint'(complete), 64'hFFFF_FFFF);
        m_fc4 = sat(m_fc4 + longint'(complete), 15);
        m_ec  = sat(m_ec + longint'(complete && (runt || gb)) + longint'(proto), 64'hFFFF_FFFF);
        m_ec4 = sat(m_ec4 + longint'(complete && (runt || gs)) + longint'(proto), 15);
      end
    end
    x.due = cyc + 1;       x.done = complete;       x.proto = proto;
    x.len_b = sat(m_len, 65535); x.runt_b = runt;    x.giant_b = complete && gb;
    x.len_s = sat(m_len, 15);    x.runt_s = runt;    x.giant_s = complete && gs;
    x.fc = m_fc; x.ec = m_ec; x.fc4 = m_fc4; x.ec4 = m_ec4;
    sb.push_back(x);
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard consumer: compare every cycle's outputs with the popped expectation
  always @(negedge i_clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      x = sb.pop_front();
      total = total + 6;
      if ({o_done, o_runt, o_giant, o_protoErr} !== {x.done, x.runt_b, x.giant_b, x.proto}) begin
        bad++;
        $display("FAIL sb_status cyc=%0d got done/runt/giant/proto=%b expected=%b", cyc,
                 {o_done, o_runt, o_giant, o_protoErr}, {x.done, x.runt_b, x.giant_b, x.proto});
      end
      if (o_frameLen !== 16'(x.len_b)) begin
        bad++;
        $display("FAIL sb_len cyc=%0d got=%0d expected=%0d", cyc, o_frameLen, x.len_b);
      end
      if ({o_frameCount, o_errCount} !== {32'(x.fc), 32'(x.ec)}) begin
        bad++;
        $display("FAIL sb_counts cyc=%0d got fc=%0d ec=%0d expected fc=%0d ec=%0d", cyc,
                 o_frameCount, o_errCount, x.fc, x.ec);
      end
      if ({s_done, s_runt, s_giant, s_proto_err} !== {x.done, x.runt_s, x.giant_s, x.proto}) begin
        bad++;
        $display("FAIL sb_small_status cyc=%0d got=%b expected=%b", cyc,
                 {s_done, s_runt, s_giant, s_proto_err}, {x.done, x.runt_s, x.giant_s, x.proto});
      end
      if (s_frame_len !== 4'(x.len_s)) begin
        bad++;
        $display("FAIL sb_small_len cyc=%0d got=%0d expected=%0d", cyc, s_frame_len, x.len_s);
      end
      if ({s_frame_count, s_err_count} !== {4'(x.fc4), 4'(x.ec4)}) begin
        bad++;
        $display("FAIL sb_small_counts cyc=%0d got fc=%0d ec=%0d expected fc=%0d ec=%0d", cyc,
                 s_frame_count, s_err_count, x.fc4, x.ec4);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      x = sb.pop_front();
      total++; bad++;
      $display("FAIL sb_stale cyc=%0d got=unchecked expected due=%0d", cyc, x.due);
    end
  end

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    total++;
    if ({o_done, o_runt, o_giant, o_protoErr, o_frameLen, o_frameCount, o_errCount} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got done=%b len=%0d fc=%0d ec=%0d expected all 0",
               o_done, o_frameLen, o_frameCount, o_errCount);
    end
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic test_basic_frame();
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    total++;
    if (o_done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b expected=0", o_done); end
    drive(1, 1, 0, 1, 0);
    total++;
    if ({o_done, o_runt, o_giant} !== 3'b100 || o_frameLen !== 16'd5 || o_frameCount !== 32'd1) begin
      bad++;
      $display("FAIL basic_frame got done/runt/giant=%b len=%0d fc=%0d expected 100 len=5 fc=1",
               {o_done, o_runt, o_giant}, o_frameLen, o_frameCount);
    end
    drive(1, 0, 0, 0, 0);
    total++;
    if (o_done !== 1'b0 || o_frameLen !== 16'd5) begin
      bad++;
      $display("FAIL basic_hold got done=%b len=%0d expected done=0 len=5", o_done, o_frameLen);
    end
  endtask

  task automatic test_single_beat();
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0);
    total++;
    if ({o_done, o_runt, o_giant} !== 3'b110 || o_frameLen !== 16'd1 ||
        o_errCount !== 32'd1 || o_frameCount !== 32'd1) begin
      bad++;
      $display("FAIL single_beat got done/runt/giant=%b len=%0d fc=%0d ec=%0d expected 110 len=1 fc=1 ec=1",
               {o_done, o_runt, o_giant}, o_frameLen, o_frameCount, o_errCount);
    end
    drive(1, 0, 0, 0, 0);
    total++;
    if (o_runt !== 1'b0) begin bad++; $display("FAIL single_runt_clear got=%b expected=0", o_runt); end
  endtask

  task automatic test_abandon();
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    total++;
    if (o_protoErr !== 1'b1 || o_done !== 1'b0 || o_errCount !== 32'd1) begin
      bad++;
      $display("FAIL abandon_sop got proto=%b done=%b ec=%0d expected proto=1 done=0 ec=1",
               o_protoErr, o_done, o_errCount);
    end
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_done !== 1'b1 || o_frameLen !== 16'd5 || o_frameCount !== 32'd1 || o_errCount !== 32'd1) begin
      bad++;
      $display("FAIL abandon_frame got done=%b len=%0d fc=%0d ec=%0d expected done=1 len=5 fc=1 ec=1",
               o_done, o_frameLen, o_frameCount, o_errCount);
    end
  endtask

  task automatic test_giant_gaps();
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 68; i++) begin
      if (i % 5 == 2) drive(1, 0, 1, 1, 0);
      if (i % 7 == 3) drive(1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
    end
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_done !== 1'b1 || o_frameLen !== 16'd70 || o_giant !== 1'b1 || o_runt !== 1'b0) begin
      bad++;
      $display("FAIL giant got done=%b len=%0d giant=%b runt=%b expected done=1 len=70 giant=1 runt=0",
               o_done, o_frameLen, o_giant, o_runt);
    end
    total++;
    if (s_frame_len !== 4'd15 || s_giant !== 1'b1) begin
      bad++;
      $display("FAIL giant_len_sat got len=%0d giant=%b expected len=15 giant=1", s_frame_len, s_giant);
    end
  endtask

  task automatic test_idle_eop_clear();
    longint unsigned ec_before = m_ec;
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_protoErr !== 1'b1 || o_done !== 1'b0 || o_errCount !== 32'(ec_before + 1)) begin
      bad++;
      $display("FAIL idle_eop got proto=%b done=%b ec=%0d expected proto=1 done=0 ec=%0d",
               o_protoErr, o_done, o_errCount, ec_before + 1);
    end
    drive(1, 0, 0, 0, 1);
    total++;
    if (o_frameCount !== 32'd0 || o_errCount !== 32'd0) begin
      bad++;
      $display("FAIL clear got fc=%0d ec=%0d expected 0 0", o_frameCount, o_errCount);
    end
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 1);
    total++;
    if (o_done !== 1'b1 || o_frameLen !== 16'd2 || o_frameCount !== 32'd0 || o_errCount !== 32'd0) begin
      bad++;
      $display("FAIL clear_priority got done=%b len=%0d fc=%0d ec=%0d expected done=1 len=2 fc=0 ec=0",
               o_done, o_frameLen, o_frameCount, o_errCount);
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) drive(1, 1, 0, 1, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 0);
    total++;
    if (s_err_count !== 4'd15 || o_errCount !== 32'd16) begin
      bad++;
      $display("FAIL err_plus2_sat got small=%0d big=%0d expected small=15 big=16", s_err_count, o_errCount);
    end
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    total++;
    if (s_err_count !== 4'd15 || o_errCount !== 32'd19) begin
      bad++;
      $display("FAIL err_sticky got small=%0d big=%0d expected small=15 big=19", s_err_count, o_errCount);
    end
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) drive(1, 1, 1, 1, 0);
    total++;
    if (s_frame_count !== 4'd15 || o_frameCount !== 32'd17 || s_err_count !== 4'd15) begin
      bad++;
      $display("FAIL frame_sat got small_fc=%0d big_fc=%0d small_ec=%0d expected 15 17 15",
               s_frame_count, o_frameCount, s_err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    total++;
    if ({o_done, o_runt, o_giant, o_protoErr, o_frameLen, o_frameCount, o_errCount,
         s_frame_count, s_err_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid got done=%b len=%0d fc=%0d ec=%0d expected all 0",
               o_done, o_frameLen, o_frameCount, o_errCount);
    end
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_done !== 1'b0 || o_protoErr !== 1'b1 || o_frameCount !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_eop got done=%b proto=%b fc=%0d expected done=0 proto=1 fc=0",
               o_done, o_protoErr, o_frameCount);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_done !== 1'b1 || o_frameLen !== 16'd2 || o_runt !== 1'b1) begin
      bad++;
      $display("FAIL b2b_len2 got done=%b len=%0d runt=%b expected done=1 len=2 runt=1", o_done, o_frameLen, o_runt);
    end
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    total++;
    if (o_done !== 1'b1 || o_frameLen !== 16'd4 || o_runt !== 1'b0 || o_frameCount !== 32'd4) begin
      bad++;
      $display("FAIL b2b_len4 got done=%b len=%0d runt=%b fc=%0d expected done=1 len=4 runt=0 fc=4",
               o_done, o_frameLen, o_runt, o_frameCount);
    end
    drive(1, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_abandon();
    test_giant_gaps();
    test_idle_eop_clear();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    @(negedge i_clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d expected=0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
